fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 65 ++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, instruction field positions, opcodes.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 4;

  // Instruction word layout: opcode | Rd | Rn | Rm
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RN_MSB  = 7;
  localparam int unsigned RN_LSB  = 4;
  localparam int unsigned RM_MSB  = 3;
  localparam int unsigned RM_LSB  = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_LDR  = 4'h5,
    OP_STR  = 4'h6,
    OP_MOV  = 4'h7,
    OP_B    = 4'h8,
    OP_BL   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_CMP  = 4'hB,
    OP_DISP = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  // Extract the opcode field of an instruction word.
  function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer with push, pop, flush and occupancy count.
module fetch_fifo #(
  parameter int unsigned W     = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointer/count state; flush wins over push and pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write at tail; contents need no reset because count gates the read
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= wdata;
  end

  assign rdata = (count_q != '0) ? mem_q[head_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register plus push/pop/redirect control around the prefetch queue.
module fetch_unit #(
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
  parameter int unsigned PC_W    = cpu_pkg::PC_W,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic                   ins_valid,
  input  logic                   ins_ready,
  output logic [INSTR_W-1:0]     instruction,
  output logic [PC_W-1:0]        ins_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = INSTR_W + PC_W;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            push_c, pop_c;
  logic [EW-1:0]   head_entry;

  // Handshake decode; redirect suppresses both queue operations
  always_comb begin
    pop_c  = ins_valid && ins_ready && !redirect_valid;
    push_c = fetch_en && !redirect_valid && ((count < CW'(DEPTH)) || pop_c);
  end

  // Next PC: redirect target, else sequential after a push, else hold
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (push_c)     pc_d = pc_q + PC_W'(1);
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .flush (redirect_valid),
    .wdata ({imem_data, pc_q}),
    .rdata (head_entry),
    .count (count)
  );

  assign imem_addr               = pc_q;
  assign ins_valid               = (count != '0);
  assign {instruction, ins_pc}   = head_entry;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected words queued at stimulus, compared on handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_pc = 4'd0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [15:0] instruction;
  logic [3:0]  ins_pc;
  logic [2:0]  count;

  logic [15:0] imem [16];

  typedef struct {
    logic [15:0] ins;
    logic [3:0]  pc;
  } exp_t;

  exp_t sb [$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .instruction    (instruction),
    .ins_pc         (ins_pc),
    .count          (count)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [3:0] pc);
    exp_t e;
    e.ins = imem[pc];
    e.pc  = pc;
    sb.push_back(e);
  endtask

  // Compare the head word against the scoreboard whenever a pop will commit
  task automatic observe();
    exp_t e;
    if (ins_valid && ins_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_delivery", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("ins_word", 32'(instruction), 32'(e.ins));
        chk("ins_pc", 32'(ins_pc), 32'(e.pc));
      end
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then observe
  task automatic tick(input logic fe, input logic rdy, input logic rv, input logic [3:0] rpc);
    @(negedge clk);
    fetch_en       = fe;
    ins_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    observe();
  endtask

  task automatic drain(input logic fe, input logic rdy, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (sb.size() == 0) break;
      tick(fe, rdy, 1'b0, 4'd0);
    end
    chk("drain_left", 32'(sb.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    fetch_en       = 1'b0;
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 16'h1000 + 16'(i);

    // Reset state
    #1;
    chk("rst_valid", 32'(ins_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_ins_pc", 32'(ins_pc), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    #1 rst = 1'b0;

    // First fetch after reset: no bypass, visible the following cycle
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("first_valid_early", 32'(ins_valid), 0);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("first_valid", 32'(ins_valid), 1);
    chk("first_pc", 32'(ins_pc), 0);
    chk("first_instr", 32'(instruction), 32'h1000);
    chk("first_count", 32'(count), 1);

    // Streaming with PC wrap
    do_reset();
    for (int i = 0; i < 16; i++) expect_pc(4'(i));
    expect_pc(4'd0);
    drain(1'b1, 1'b1, 40);

    // Backpressure, then full queue with continuous pop
    do_reset();
    repeat (10) tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("bp_count_sat", 32'(count), 4);
    chk("bp_addr_hold", 32'(imem_addr), 4);
    for (int i = 0; i < 8; i++) expect_pc(4'(i));
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, 4'd0);
      chk("full_pop_count", 32'(count), 4);
      chk("full_pop_valid", 32'(ins_valid), 1);
    end
    drain(1'b1, 1'b1, 20);

    // Redirect with three entries queued
    do_reset();
    repeat (3) tick(1'b1, 1'b0, 1'b0, 4'd0);
    expect_pc(4'd9);
    expect_pc(4'd10);
    expect_pc(4'd11);
    tick(1'b1, 1'b1, 1'b1, 4'd9);
    chk("redir_count_before", 32'(count), 3);
    tick(1'b1, 1'b1, 1'b0, 4'd0);
    chk("redir_valid_n1", 32'(ins_valid), 0);
    chk("redir_count_n1", 32'(count), 0);
    drain(1'b1, 1'b1, 20);

    // Asynchronous reset mid-run with two entries queued
    do_reset();
    repeat (2) tick(1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("mid_count_before", 32'(count), 2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ins_valid), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_instr", 32'(instruction), 0);
    #1 rst = 1'b0;
    expect_pc(4'd0);
    expect_pc(4'd1);
    expect_pc(4'd2);
    drain(1'b1, 1'b1, 20);

    // Redirect while fetch disabled, then resume at target
    tick(1'b0, 1'b1, 1'b1, 4'd5);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b0, 4'd0);
      chk("fe_low_count", 32'(count), 0);
      chk("fe_low_valid", 32'(ins_valid), 0);
      chk("fe_low_addr", 32'(imem_addr), 5);
    end
    expect_pc(4'd5);
    expect_pc(4'd6);
    expect_pc(4'd7);
    drain(1'b1, 1'b1, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
